// File: rtl/sha256_bit_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : sha256_bit_sequencer_if
// Description : Handshake and bit-timing bundle between the hash FSM, the
//               bit sequencer and the bit-serial datapath units.
// Revision    : 1.0
// ============================================================================
interface sha256_bit_sequencer_if #(
    parameter int W      = 32,
    parameter int ROUNDS = 64
);
    logic                      start;
    logic                      stall;
    logic                      bclk;
    logic [$clog2(W)-1:0]      counter;
    logic [$clog2(ROUNDS)-1:0] round;
    logic                      bit_first;
    logic                      bit_last;
    logic                      sched_sel;
    logic                      draining;
    logic                      busy;
    logic                      done;

    // The sequencer is the timing master; controllers and consumers are slaves.
    modport master (
        input  start, stall,
        output bclk, counter, round, bit_first, bit_last,
               sched_sel, draining, busy, done
    );

    modport slave (
        output start, stall,
        input  bclk, counter, round, bit_first, bit_last,
               sched_sel, draining, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/sha256_bit_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : sha256_bit_sequencer
// Description : Bit strobe, bit index and round sequencer for the bit-serial
//               SHA-256 datapath, with start/busy/done handshake.
// Revision    : 1.0
// ============================================================================
module sha256_bit_sequencer #(
    parameter int W           = 32,
    parameter int ROUNDS      = 64,
    parameter int DIV         = 2,
    parameter int SCHED_START = 16,
    parameter int DRAIN_WORDS = 1
) (
    input  wire logic               clk,
    input  wire logic               rst,
    sha256_bit_sequencer_if.master  bus
);
    localparam int c_CW  = $clog2(W);
    localparam int c_RW  = $clog2(ROUNDS);
    localparam int c_DVW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int c_DCW = (DRAIN_WORDS > 1) ? $clog2(DRAIN_WORDS) : 1;

    localparam logic [c_CW-1:0]  c_CNT_LAST = c_CW'(W - 1);
    localparam logic [c_CW-1:0]  c_CNT_ONE  = c_CW'(1);
    localparam logic [c_RW-1:0]  c_RND_LAST = c_RW'(ROUNDS - 1);
    localparam logic [c_RW-1:0]  c_RND_ONE  = c_RW'(1);
    localparam logic [c_DVW-1:0] c_DIV_LAST = c_DVW'(DIV - 1);
    localparam logic [c_DVW-1:0] c_DIV_ONE  = c_DVW'(1);
    localparam logic [c_DCW-1:0] c_DRN_LAST = c_DCW'((DRAIN_WORDS > 0) ? DRAIN_WORDS - 1 : 0);
    localparam logic [c_DCW-1:0] c_DRN_ONE  = c_DCW'(1);

    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_RUN   = 2'd1;
    localparam logic [1:0] c_S_DRAIN = 2'd2;
    localparam logic [1:0] c_S_DONE  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = c_S_IDLE,
        ST_RUN   = c_S_RUN,
        ST_DRAIN = c_S_DRAIN,
        ST_DONE  = c_S_DONE
    } state_t;

    state_t           r_state,     w_state_nxt;
    logic [c_DVW-1:0] r_div_cnt,   w_div_nxt;
    logic             r_half,      w_half_nxt;
    logic [c_CW-1:0]  r_counter,   w_cnt_nxt;
    logic [c_RW-1:0]  r_round,     w_rnd_nxt;
    logic [c_DCW-1:0] r_drain_cnt, w_drn_nxt;

    logic r_bclk,      w_bclk_nxt;
    logic r_bit_first, w_first_nxt;
    logic r_bit_last,  w_last_nxt;
    logic r_sched_sel, w_sched_nxt;
    logic r_draining,  w_drain_nxt;
    logic r_busy,      w_busy_nxt;
    logic r_done,      w_done_nxt;
    logic w_active;

    always_comb begin
        w_state_nxt = r_state;
        w_div_nxt   = r_div_cnt;
        w_half_nxt  = r_half;
        w_cnt_nxt   = r_counter;
        w_rnd_nxt   = r_round;
        w_drn_nxt   = r_drain_cnt;

        unique case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = ST_RUN;
                    w_div_nxt   = '0;
                    w_half_nxt  = 1'b0;
                    w_cnt_nxt   = '0;
                    w_rnd_nxt   = '0;
                    w_drn_nxt   = '0;
                end
            end
            ST_RUN, ST_DRAIN: begin
                if (!bus.stall) begin
                    if (r_div_cnt != c_DIV_LAST) begin
                        w_div_nxt = r_div_cnt + c_DIV_ONE;
                    end else begin
                        w_div_nxt = '0;
                        if (!r_half) begin
                            w_half_nxt = 1'b1;
                        end else begin
                            // Bit period ends here; index/round only move on the rising strobe.
                            w_half_nxt = 1'b0;
                            if (r_counter != c_CNT_LAST) begin
                                w_cnt_nxt = r_counter + c_CNT_ONE;
                            end else begin
                                w_cnt_nxt = '0;
                                if (r_state == ST_RUN) begin
                                    if (r_round != c_RND_LAST) begin
                                        w_rnd_nxt = r_round + c_RND_ONE;
                                    end else if (DRAIN_WORDS == 0) begin
                                        w_state_nxt = ST_DONE;
                                        w_rnd_nxt   = '0;
                                    end else begin
                                        w_state_nxt = ST_DRAIN;
                                        w_drn_nxt   = '0;
                                    end
                                end else if (r_drain_cnt == c_DRN_LAST) begin
                                    w_state_nxt = ST_DONE;
                                    w_rnd_nxt   = '0;
                                end else begin
                                    w_drn_nxt = r_drain_cnt + c_DRN_ONE;
                                end
                            end
                        end
                    end
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Outputs are decoded from next-state so they leave a register directly.
        w_active    = (w_state_nxt == ST_RUN) || (w_state_nxt == ST_DRAIN);
        w_bclk_nxt  = w_active && !w_half_nxt;
        w_first_nxt = w_active && (w_cnt_nxt == '0);
        w_last_nxt  = w_active && (w_cnt_nxt == c_CNT_LAST);
        w_sched_nxt = (w_state_nxt == ST_RUN) && (int'(w_rnd_nxt) >= SCHED_START);
        w_drain_nxt = (w_state_nxt == ST_DRAIN);
        w_busy_nxt  = w_active;
        w_done_nxt  = (w_state_nxt == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_div_cnt   <= '0;
            r_half      <= 1'b0;
            r_counter   <= '0;
            r_round     <= '0;
            r_drain_cnt <= '0;
            r_bclk      <= 1'b0;
            r_bit_first <= 1'b0;
            r_bit_last  <= 1'b0;
            r_sched_sel <= 1'b0;
            r_draining  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_div_cnt   <= w_div_nxt;
            r_half      <= w_half_nxt;
            r_counter   <= w_cnt_nxt;
            r_round     <= w_rnd_nxt;
            r_drain_cnt <= w_drn_nxt;
            r_bclk      <= w_bclk_nxt;
            r_bit_first <= w_first_nxt;
            r_bit_last  <= w_last_nxt;
            r_sched_sel <= w_sched_nxt;
            r_draining  <= w_drain_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
        end
    end

    assign bus.bclk      = r_bclk;
    assign bus.counter   = r_counter;
    assign bus.round     = r_round;
    assign bus.bit_first = r_bit_first;
    assign bus.bit_last  = r_bit_last;
    assign bus.sched_sel = r_sched_sel;
    assign bus.draining  = r_draining;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
endmodule
`default_nettype wire

// File: tb/tb_sha256_bit_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_sha256_bit_sequencer
// Description : Self-checking bench: timing tables, hand sequences and a
//               randomized run against a progress-count reference model.
// Revision    : 1.0
// ============================================================================
module tb_sha256_bit_sequencer;
    localparam int c_TRACE_N = 11400;

    typedef struct packed {
        logic       bclk;
        logic [7:0] counter;
        logic [7:0] round;
        logic       first;
        logic       last;
        logic       sched;
        logic       drain;
        logic       busy;
        logic       done;
    } outs_t;

    typedef struct { int cyc; outs_t exp; } vec_t;
    typedef struct { int w; int rounds; int div; int ss; int dw; } cfg_t;
    // mode: -1 unknown, 0 idle, 1 active (p = non-stalled cycles so far), 2 done
    typedef struct { int mode; int p; } mst_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tb_start = 1'b0;
    logic tb_stall = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    sha256_bit_sequencer_if #(.W(32), .ROUNDS(64)) m_if ();
    sha256_bit_sequencer_if #(.W(4),  .ROUNDS(2))  s_if ();
    sha256_bit_sequencer_if #(.W(3),  .ROUNDS(3))  t_if ();

    assign m_if.start = tb_start;
    assign m_if.stall = tb_stall;
    assign s_if.start = tb_start;
    assign s_if.stall = tb_stall;
    assign t_if.start = tb_start;
    assign t_if.stall = tb_stall;

    sha256_bit_sequencer #(.W(32), .ROUNDS(64), .DIV(2), .SCHED_START(16), .DRAIN_WORDS(1))
        u_main (.clk(clk), .rst(rst), .bus(m_if));
    sha256_bit_sequencer #(.W(4), .ROUNDS(2), .DIV(1), .SCHED_START(1), .DRAIN_WORDS(0))
        u_small (.clk(clk), .rst(rst), .bus(s_if));
    sha256_bit_sequencer #(.W(3), .ROUNDS(3), .DIV(3), .SCHED_START(1), .DRAIN_WORDS(2))
        u_alt (.clk(clk), .rst(rst), .bus(t_if));

    cfg_t  cfg [3];
    mst_t  ms  [3];
    string names [3] = '{"main", "small", "alt"};
    outs_t tr_m [c_TRACE_N];
    outs_t tr_s [c_TRACE_N];
    vec_t  tv_m [15];
    vec_t  tv_s [8];

    function automatic outs_t mk(logic bclk, int cnt, int rnd, logic f, logic l,
                                 logic sc, logic dr, logic bu, logic dn);
        outs_t o;
        o.bclk = bclk; o.counter = 8'(cnt); o.round = 8'(rnd);
        o.first = f; o.last = l; o.sched = sc; o.drain = dr; o.busy = bu; o.done = dn;
        return o;
    endfunction

    function automatic vec_t vec(int cyc, outs_t e);
        vec_t v;
        v.cyc = cyc; v.exp = e;
        return v;
    endfunction

    function automatic outs_t model_out(mst_t s, cfg_t c);
        outs_t o = '0;
        int    b, bit_idx, word, rnd;
        logic  drn;
        if (s.mode == 2) begin
            o.done = 1'b1;
        end else if (s.mode == 1) begin
            b       = s.p / (2 * c.div);
            bit_idx = b % c.w;
            word    = b / c.w;
            drn     = (word >= c.rounds);
            rnd     = drn ? c.rounds - 1 : word;
            o.bclk    = (s.p % (2 * c.div)) < c.div;
            o.counter = 8'(bit_idx);
            o.round   = 8'(rnd);
            o.first   = (bit_idx == 0);
            o.last    = (bit_idx == c.w - 1);
            o.sched   = !drn && (rnd >= c.ss);
            o.drain   = drn;
            o.busy    = 1'b1;
        end
        return o;
    endfunction

    function automatic mst_t model_next(mst_t s, cfg_t c, logic r, logic st, logic sl);
        mst_t n = s;
        if (r) begin
            n.mode = 0; n.p = 0;
        end else begin
            case (s.mode)
                0: if (st) begin n.mode = 1; n.p = 0; end
                1: if (!sl) begin
                    n.p = s.p + 1;
                    if (n.p >= (c.rounds + c.dw) * c.w * 2 * c.div) begin
                        n.mode = 2; n.p = 0;
                    end
                end
                2: n.mode = 0;
                default: n.mode = s.mode;
            endcase
        end
        return n;
    endfunction

    task automatic check_outs(string name, int idx, outs_t act, outs_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0d: got bclk=%b cnt=%0d rnd=%0d first=%b last=%b sched=%b drain=%b busy=%b done=%b, expected bclk=%b cnt=%0d rnd=%0d first=%b last=%b sched=%b drain=%b busy=%b done=%b",
                     name, idx, act.bclk, act.counter, act.round, act.first, act.last,
                     act.sched, act.drain, act.busy, act.done, exp.bclk, exp.counter,
                     exp.round, exp.first, exp.last, exp.sched, exp.drain, exp.busy, exp.done);
        end
    endtask

    task automatic check_int(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Inputs for cycle c are applied now, outputs sampled at the falling edge.
    task automatic tick(int c, logic s, logic sl, logic r);
        outs_t a [3];
        tb_start = s;
        tb_stall = sl;
        rst      = r;
        @(negedge clk);
        a[0] = mk(m_if.bclk, int'(m_if.counter), int'(m_if.round), m_if.bit_first, m_if.bit_last,
                  m_if.sched_sel, m_if.draining, m_if.busy, m_if.done);
        a[1] = mk(s_if.bclk, int'(s_if.counter), int'(s_if.round), s_if.bit_first, s_if.bit_last,
                  s_if.sched_sel, s_if.draining, s_if.busy, s_if.done);
        a[2] = mk(t_if.bclk, int'(t_if.counter), int'(t_if.round), t_if.bit_first, t_if.bit_last,
                  t_if.sched_sel, t_if.draining, t_if.busy, t_if.done);
        for (int k = 0; k < 3; k++)
            if (ms[k].mode >= 0) check_outs(names[k], c, a[k], model_out(ms[k], cfg[k]));
        if (c >= 0 && c < c_TRACE_N) begin
            tr_m[c] = a[0];
            tr_s[c] = a[1];
        end
        for (int k = 0; k < 3; k++) ms[k] = model_next(ms[k], cfg[k], r, s, sl);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        tick(-1, 1'b0, 1'b0, 1'b1);
        tick(-1, 1'b1, 1'b1, 1'b1);
        tick(-1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int cnt;
        cfg[0] = '{32, 64, 2, 16, 1};
        cfg[1] = '{4, 2, 1, 1, 0};
        cfg[2] = '{3, 3, 3, 1, 2};
        for (int k = 0; k < 3; k++) ms[k] = '{-1, 0};

        tv_m[0]  = vec(0,    mk(0, 0,  0,  0, 0, 0, 0, 0, 0));
        tv_m[1]  = vec(1,    mk(1, 0,  0,  1, 0, 0, 0, 1, 0));
        tv_m[2]  = vec(2,    mk(1, 0,  0,  1, 0, 0, 0, 1, 0));
        tv_m[3]  = vec(3,    mk(0, 0,  0,  1, 0, 0, 0, 1, 0));
        tv_m[4]  = vec(5,    mk(1, 1,  0,  0, 0, 0, 0, 1, 0));
        tv_m[5]  = vec(125,  mk(1, 31, 0,  0, 1, 0, 0, 1, 0));
        tv_m[6]  = vec(128,  mk(0, 31, 0,  0, 1, 0, 0, 1, 0));
        tv_m[7]  = vec(129,  mk(1, 0,  1,  1, 0, 0, 0, 1, 0));
        tv_m[8]  = vec(2048, mk(0, 31, 15, 0, 1, 0, 0, 1, 0));
        tv_m[9]  = vec(2049, mk(1, 0,  16, 1, 0, 1, 0, 1, 0));
        tv_m[10] = vec(8192, mk(0, 31, 63, 0, 1, 1, 0, 1, 0));
        tv_m[11] = vec(8193, mk(1, 0,  63, 1, 0, 0, 1, 1, 0));
        tv_m[12] = vec(8320, mk(0, 31, 63, 0, 1, 0, 1, 1, 0));
        tv_m[13] = vec(8321, mk(0, 0,  0,  0, 0, 0, 0, 0, 1));
        tv_m[14] = vec(8322, mk(0, 0,  0,  0, 0, 0, 0, 0, 0));

        tv_s[0] = vec(1,  mk(1, 0, 0, 1, 0, 0, 0, 1, 0));
        tv_s[1] = vec(2,  mk(0, 0, 0, 1, 0, 0, 0, 1, 0));
        tv_s[2] = vec(7,  mk(1, 3, 0, 0, 1, 0, 0, 1, 0));
        tv_s[3] = vec(8,  mk(0, 3, 0, 0, 1, 0, 0, 1, 0));
        tv_s[4] = vec(9,  mk(1, 0, 1, 1, 0, 1, 0, 1, 0));
        tv_s[5] = vec(16, mk(0, 3, 1, 0, 1, 1, 0, 1, 0));
        tv_s[6] = vec(17, mk(0, 0, 0, 0, 0, 0, 0, 0, 1));
        tv_s[7] = vec(18, mk(0, 0, 0, 0, 0, 0, 0, 0, 0));

        // Nominal block
        do_reset();
        for (int c = 0; c < 8340; c++) tick(c, c == 0, 1'b0, 1'b0);
        for (int i = 0; i < 15; i++) check_outs("nominal_main", tv_m[i].cyc, tr_m[tv_m[i].cyc], tv_m[i].exp);
        for (int i = 0; i < 8; i++)  check_outs("nominal_small", tv_s[i].cyc, tr_s[tv_s[i].cyc], tv_s[i].exp);

        // Stall mid-period
        do_reset();
        for (int c = 0; c < 8340; c++) tick(c, c == 0, (c >= 6) && (c <= 15), 1'b0);
        check_outs("stall_hold",   16,   tr_m[16],   mk(1, 1,  0,  0, 0, 0, 0, 1, 0));
        check_outs("stall_fall",   17,   tr_m[17],   mk(0, 1,  0,  0, 0, 0, 0, 1, 0));
        check_outs("stall_resume", 19,   tr_m[19],   mk(1, 2,  0,  0, 0, 0, 0, 1, 0));
        check_outs("stall_last",   8330, tr_m[8330], mk(0, 31, 63, 0, 1, 0, 1, 1, 0));
        check_outs("stall_done",   8331, tr_m[8331], mk(0, 0,  0,  0, 0, 0, 0, 0, 1));
        cnt = 0;
        for (int c = 6; c <= 16; c++) if (tr_m[c].bclk != tr_m[c-1].bclk) cnt++;
        check_int("stall_no_edge", cnt, 0);

        // Reset mid-operation, then a fresh start
        do_reset();
        for (int c = 0; c < 3005 + 8330; c++) tick(c, (c == 0) || (c == 3005), 1'b0, c == 3000);
        check_outs("rst_idle",    3001,        tr_m[3001],        mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        check_outs("rst_restart", 3006,        tr_m[3006],        mk(1, 0, 0, 1, 0, 0, 0, 1, 0));
        check_outs("rst_round1",  3005 + 129,  tr_m[3005 + 129],  mk(1, 0, 1, 1, 0, 0, 0, 1, 0));
        check_outs("rst_done",    3005 + 8321, tr_m[3005 + 8321], mk(0, 0, 0, 0, 0, 0, 0, 0, 1));
        cnt = 0;
        for (int c = 0; c < 3005; c++) if (tr_m[c].done) cnt++;
        check_int("rst_no_done", cnt, 0);
        cnt = 0;
        for (int c = 0; c < 3005 + 8330; c++) if (tr_m[c].done) cnt++;
        check_int("rst_done_count", cnt, 1);

        // Start held high throughout
        do_reset();
        for (int c = 0; c < 8330; c++) tick(c, 1'b1, 1'b0, 1'b0);
        check_outs("hold_busy",  4000, tr_m[4000], mk(0, 7, 31, 0, 0, 1, 0, 1, 0));
        check_outs("hold_done",  8321, tr_m[8321], mk(0, 0, 0,  0, 0, 0, 0, 0, 1));
        check_outs("hold_idle",  8322, tr_m[8322], mk(0, 0, 0,  0, 0, 0, 0, 0, 0));
        check_outs("hold_rerun", 8323, tr_m[8323], mk(1, 0, 0,  1, 0, 0, 0, 1, 0));
        check_outs("hold_small_idle", 18, tr_s[18], mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        check_outs("hold_small_rerun", 19, tr_s[19], mk(1, 0, 0, 1, 0, 0, 0, 1, 0));
        check_outs("hold_small_done2", 35, tr_s[35], mk(0, 0, 0, 0, 0, 0, 0, 0, 1));

        // Randomized start/stall/reset against the model
        do_reset();
        for (int c = 0; c < 4000; c++)
            tick(-1, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 199) == 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/sha256_bit_sequencer.md
Name: sha256_bit_sequencer

Overview:
- Master timing controller for the bit-serial SHA-256 datapath.
- Generates the bit strobe `bclk` and the bit index `counter` shared by all rotate/shift/add bit-serial units.
  - Consumers record a bit on the rising edge of `bclk` and play a bit on its falling edge.
- Sequences the 64 compression rounds, then drains the W-bit serial pipelines.
- Runs under a start/busy/done handshake from the top-level hash FSM.

Parameters:
- W, 32, word width in bits (bit periods per round); W >= 2.
- ROUNDS, 64, rounds per block; ROUNDS >= 2.
- DIV, 2, clk cycles per `bclk` half-period; DIV >= 1.
- SCHED_START, 16, first round in which the message schedule is computed rather than loaded.
- DRAIN_WORDS, 1, extra words of bit periods after the last round that flush the serial pipelines.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, synchronous active-high reset.
- start, input, 1, begin one block; sampled only in IDLE.
- stall, input, 1, freeze sequencing; holds all outputs; effective in RUN and DRAIN only.
- bclk, output, 1, bit strobe: high for DIV cycles, then low for DIV cycles, per bit period.
- counter, output, $clog2(W), index of the bit in the current period; 0 = LSB.
- round, output, $clog2(ROUNDS), current round.
- bit_first, output, 1, `counter` == 0 and RUN/DRAIN.
- bit_last, output, 1, `counter` == W-1 and RUN/DRAIN.
- sched_sel, output, 1, RUN and `round` >= SCHED_START.
- draining, output, 1, state is DRAIN.
- busy, output, 1, state is RUN or DRAIN.
- done, output, 1, single-cycle completion pulse.

Behaviour:
- States: IDLE, RUN, DRAIN, DONE. Internal registers: `div_cnt` (0..DIV-1), `half` (0 = high, 1 = low), `drain_cnt`.
- Reset (sync, any state, including mid-operation): the next cycle is IDLE.
  - `bclk`=0, `counter`=0, `round`=0, `busy`=0, `done`=0, `draining`=0, `div_cnt`=0, `half`=0.
  - No partial `done` is issued; the datapath must be restarted.
- IDLE:
  - `bclk`=0; all outputs at reset values.
  - `start`=1 at edge t gives RUN at t+1 with `bclk`=1, `counter`=0, `round`=0.
- Bit period: 2*DIV non-stalled cycles.
  - `bclk`=1 for the first DIV cycles, 0 for the next DIV.
  - `counter` and `round` change only on the cycle where `bclk` goes 0->1, never while `bclk`=1. This keeps them stable for one-cycle-late edge detectors.
- End of bit period:
  - If `counter` < W-1: `counter`+1.
  - Else: `counter` wraps to 0, and the state advances:
    - RUN with `round` < ROUNDS-1: `round`+1.
    - RUN with `round` = ROUNDS-1: enter DRAIN.
    - DRAIN: `drain_cnt`+1; when `drain_cnt` = DRAIN_WORDS-1, go to DONE.
- DRAIN:
  - `round` holds ROUNDS-1; `draining`=1; `sched_sel`=0; `bclk` and `counter` continue identically to RUN.
  - If DRAIN_WORDS=0, RUN goes directly to DONE.
- DONE:
  - `done`=1 for exactly 1 cycle; `bclk`=0; `counter`=0; `round`=0; `busy`=0.
  - Next cycle is IDLE.
  - `start` asserted in DONE is ignored; the next block requires `start` in IDLE.
- Stall:
  - While `stall`=1 in RUN/DRAIN, `div_cnt`, `half`, `counter`, `round`, `drain_cnt` and `bclk` are frozen; the level is held, so no `bclk` edges occur.
  - Release resumes mid-period with the remaining cycles of that half unchanged.
  - `stall` and `rst` together: `rst` wins.
- `start` while `busy` is ignored.
- Latency (DIV=2, W=32, ROUNDS=64, DRAIN_WORDS=1, no stall):
  - `start` sampled at cycle 0.
  - RUN occupies cycles 1..8192.
  - DRAIN occupies cycles 8193..8320.
  - `done` is high at cycle 8321.
  - IDLE from cycle 8322.
- All outputs are registered. No combinational path from `start` or `stall` to any output.

Test Plan:
- Nominal block, defaults:
  - `start` pulse at cycle 0 -> `bclk` rises at cycles 1, 5, 9, …
  - `counter` steps 0,1,…,31 with each rise.
  - `round` increments at cycle 129 (0->1).
  - `sched_sel` rises at cycle 2049 (`round`=16).
  - `draining`=1 over cycles 8193..8320.
  - `done`=1 only at cycle 8321.
- Stall:
  - `stall`=1 for cycles 6..15 (`bclk`=1 held, `counter`=1) -> no `bclk` edge during the stall.
  - `bclk` falls at cycle 17; `counter`=2 at cycle 19.
  - `done` is delayed exactly 10 cycles, to cycle 8331.
- Reset mid-operation:
  - `rst` at cycle 3000 -> cycle 3001 has IDLE, `bclk`=0, `counter`=0, `round`=0, `busy`=0.
  - No `done` is issued.
  - A fresh `start` at cycle 3005 reproduces the nominal timing offset by 3005.
- Ignored start:
  - `start` held high continuously from cycle 0 -> `start` is ignored while `busy` and during DONE.
  - A second block begins in IDLE; its first `bclk` rise is at cycle 8323.
- Small config (W=4, ROUNDS=2, DIV=1, DRAIN_WORDS=0, SCHED_START=1):
  - `start` at cycle 0 -> `bclk` toggles each cycle (1,0,1,0,…).
  - `counter` sequence is 0..3 twice.
  - `sched_sel` is high for cycles 9..16.
  - `done` at cycle 17; `bit_last` is high on cycles 7, 8, 15, 16.
